// File: rtl/wdg_win_pkg.sv
// Shared constants for the windowed watchdog: address map, CTRL/STAT bit
// positions, parameter defaults and the FSM state encoding.
package wdg_win_pkg;

  localparam int unsigned CNT_WIDTH_DEF  = 32;
  localparam int unsigned PSCR_WIDTH_DEF = 20;
  localparam int unsigned PSCR_MIN_DEF   = 2;
  localparam int unsigned RST_PULSE_DEF  = 16;
  localparam logic [31:0] KEY_VAL_DEF    = 32'h5F37_59DF;

  localparam logic [2:0] ADDR_CTRL = 3'd0;
  localparam logic [2:0] ADDR_PSCR = 3'd1;
  localparam logic [2:0] ADDR_CMP  = 3'd2;
  localparam logic [2:0] ADDR_WIN  = 3'd3;
  localparam logic [2:0] ADDR_EWI  = 3'd4;
  localparam logic [2:0] ADDR_STAT = 3'd5;
  localparam logic [2:0] ADDR_KEY  = 3'd6;
  localparam logic [2:0] ADDR_FEED = 3'd7;
  localparam logic [2:0] ADDR_CNT  = 3'd7;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_WIN_EN = 1;
  localparam int CTRL_EWI_EN = 2;
  localparam int CTRL_RST_EN = 3;
  localparam int CTRL_LOCK   = 4;

  localparam int STAT_EW = 0;
  localparam int STAT_TO = 1;
  localparam int STAT_EF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RST  = 2'd2
  } wdg_state_e;

endpackage

// File: rtl/wdg_tick_gen.sv
// Prescaler: counts 0..pscr-1 while enabled and emits a one-cycle tick on the
// terminal count. Clear or disable forces the count back to zero.
module wdg_tick_gen #(
  parameter int unsigned PSCR_WIDTH = wdg_win_pkg::PSCR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PSCR_WIDTH-1:0] pscr,
  output logic                  tick
);

  logic [PSCR_WIDTH-1:0] psc_r;
  logic                  at_end_s;

  assign at_end_s = (psc_r == (pscr - PSCR_WIDTH'(1)));
  assign tick     = en && !clr && at_end_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_r <= '0;
    end else if (clr || !en || at_end_s) begin
      psc_r <= '0;
    end else begin
      psc_r <= psc_r + PSCR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/wdg_win_core.sv
// Windowed watchdog core: keyed register file, feed window, early warning,
// timeout reset pulse and a combinational register read port.
module wdg_win_core #(
  parameter int unsigned CNT_WIDTH     = wdg_win_pkg::CNT_WIDTH_DEF,
  parameter int unsigned PSCR_WIDTH    = wdg_win_pkg::PSCR_WIDTH_DEF,
  parameter int unsigned PSCR_MIN_VAL  = wdg_win_pkg::PSCR_MIN_DEF,
  parameter logic [31:0] KEY_VAL       = wdg_win_pkg::KEY_VAL_DEF,
  parameter int unsigned RST_PULSE_LEN = wdg_win_pkg::RST_PULSE_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        reg_we_i,
  input  logic        reg_re_i,
  input  logic [2:0]  reg_addr_i,
  input  logic [31:0] reg_wdata_i,
  output logic [31:0] reg_rdata_o,
  output logic        irq_o,
  output logic        rst_o
);
  import wdg_win_pkg::*;

  localparam int unsigned           RC_WIDTH = (RST_PULSE_LEN > 1) ? $clog2(RST_PULSE_LEN) : 1;
  localparam logic [RC_WIDTH-1:0]   RC_LAST  = RC_WIDTH'(RST_PULSE_LEN - 1);
  localparam logic [PSCR_WIDTH-1:0] PSCR_MIN = PSCR_WIDTH'(PSCR_MIN_VAL);

  function automatic logic [PSCR_WIDTH-1:0] pscr_clamp(input logic [PSCR_WIDTH-1:0] v);
    return (v < PSCR_MIN) ? PSCR_MIN : v;
  endfunction

  logic [4:0]            ctrl_r;
  logic [PSCR_WIDTH-1:0] pscr_r;
  logic [CNT_WIDTH-1:0]  cmp_r;
  logic [CNT_WIDTH-1:0]  win_r;
  logic [CNT_WIDTH-1:0]  ewi_r;
  logic [2:0]            stat_r;
  logic [31:0]           key_r;
  logic [CNT_WIDTH-1:0]  cnt_r;
  logic [RC_WIDTH-1:0]   rst_cnt_r;
  wdg_state_e            state_r;
  logic                  irq_r;
  logic                  rst_r;

  logic        key_match_s, cfg_wr_s;
  logic        wr_ctrl_s, wr_pscr_s, wr_cmp_s, wr_win_s, wr_ewi_s, wr_stat_s;
  logic        feed_s, early_s, timeout_s, event_s, ew_hit_s, disable_s, tick_s;
  logic [4:0]  ctrl_next_s;
  logic [2:0]  stat_set_s, stat_clr_s, stat_next_s;
  logic [31:0] rdata_s;

  assign key_match_s = (key_r == KEY_VAL);
  assign cfg_wr_s    = reg_we_i && key_match_s && !ctrl_r[CTRL_LOCK];
  assign wr_ctrl_s   = cfg_wr_s && (reg_addr_i == ADDR_CTRL);
  assign wr_pscr_s   = cfg_wr_s && (reg_addr_i == ADDR_PSCR);
  assign wr_cmp_s    = cfg_wr_s && (reg_addr_i == ADDR_CMP);
  assign wr_win_s    = cfg_wr_s && (reg_addr_i == ADDR_WIN);
  assign wr_ewi_s    = cfg_wr_s && (reg_addr_i == ADDR_EWI);
  assign wr_stat_s   = reg_we_i && (reg_addr_i == ADDR_STAT);
  assign disable_s   = wr_ctrl_s && !reg_wdata_i[CTRL_EN];

  // A feed is judged against the current count and pre-empts any tick this cycle.
  assign feed_s    = reg_we_i && key_match_s && (reg_addr_i == ADDR_FEED)
                     && reg_wdata_i[0] && (state_r == RUN);
  assign early_s   = feed_s && ctrl_r[CTRL_WIN_EN] && (cnt_r < win_r);
  assign timeout_s = tick_s && !feed_s && (cnt_r >= cmp_r);
  assign event_s   = early_s || timeout_s;
  assign ew_hit_s  = tick_s && !feed_s && !timeout_s && ctrl_r[CTRL_EWI_EN]
                     && ((cnt_r + CNT_WIDTH'(1)) == ewi_r);

  assign ctrl_next_s = wr_ctrl_s ? reg_wdata_i[4:0] : ctrl_r;
  assign stat_set_s  = {early_s, timeout_s, ew_hit_s};
  assign stat_clr_s  = wr_stat_s ? reg_wdata_i[2:0] : 3'b000;
  assign stat_next_s = (stat_r & ~stat_clr_s) | stat_set_s;

  wdg_tick_gen #(
    .PSCR_WIDTH(PSCR_WIDTH)
  ) u_tick (
    .clk  (clk_i),
    .rst  (rst_i),
    .en   (state_r == RUN),
    .clr  (feed_s || wr_pscr_s),
    .pscr (pscr_r),
    .tick (tick_s)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_r    <= 5'd0;
      pscr_r    <= PSCR_MIN;
      cmp_r     <= '1;
      win_r     <= '0;
      ewi_r     <= '0;
      stat_r    <= 3'd0;
      key_r     <= 32'd0;
      cnt_r     <= '0;
      rst_cnt_r <= '0;
      state_r   <= IDLE;
      irq_r     <= 1'b0;
      rst_r     <= 1'b0;
    end else begin
      // Any non-KEY write consumes the unlock.
      if (reg_we_i) begin
        key_r <= (reg_addr_i == ADDR_KEY) ? reg_wdata_i : 32'd0;
      end
      ctrl_r <= ctrl_next_s;
      if (wr_pscr_s) pscr_r <= pscr_clamp(reg_wdata_i[PSCR_WIDTH-1:0]);
      if (wr_cmp_s)  cmp_r  <= reg_wdata_i[CNT_WIDTH-1:0];
      if (wr_win_s)  win_r  <= reg_wdata_i[CNT_WIDTH-1:0];
      if (wr_ewi_s)  ewi_r  <= reg_wdata_i[CNT_WIDTH-1:0];
      stat_r <= stat_next_s;
      irq_r  <= |(stat_next_s & {2'b11, ctrl_next_s[CTRL_EWI_EN]});

      case (state_r)
        IDLE: begin
          cnt_r     <= '0;
          rst_cnt_r <= '0;
          rst_r     <= 1'b0;
          if (wr_ctrl_s && reg_wdata_i[CTRL_EN]) state_r <= RUN;
        end
        RUN: begin
          if (disable_s) begin
            cnt_r   <= '0;
            state_r <= IDLE;
          end else if (event_s) begin
            cnt_r <= '0;
            if (ctrl_r[CTRL_RST_EN]) begin
              state_r   <= RST;
              rst_r     <= 1'b1;
              rst_cnt_r <= '0;
            end
          end else if (feed_s) begin
            cnt_r <= '0;
          end else if (tick_s) begin
            cnt_r <= cnt_r + CNT_WIDTH'(1);
          end
        end
        RST: begin
          cnt_r <= '0;
          if (disable_s) begin
            state_r <= IDLE;
            rst_r   <= 1'b0;
          end else if (rst_cnt_r == RC_LAST) begin
            state_r <= RUN;
            rst_r   <= 1'b0;
          end else begin
            rst_cnt_r <= rst_cnt_r + RC_WIDTH'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          rst_r   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rdata_s = 32'd0;
    if (reg_re_i) begin
      case (reg_addr_i)
        ADDR_CTRL: rdata_s = 32'(ctrl_r);
        ADDR_PSCR: rdata_s = 32'(pscr_r);
        ADDR_CMP:  rdata_s = 32'(cmp_r);
        ADDR_WIN:  rdata_s = 32'(win_r);
        ADDR_EWI:  rdata_s = 32'(ewi_r);
        ADDR_STAT: rdata_s = 32'(stat_r);
        ADDR_CNT:  rdata_s = 32'(cnt_r);
        default:   rdata_s = 32'd0;  // KEY is write-only
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign reg_rdata_o = rdata_s;
  assign irq_o       = irq_r;
  assign rst_o       = rst_r;

endmodule
